// File: rtl/timer_counter_cmp.sv
// 64-bit timer counter with software-loadable halves, 64-bit compare and sticky maskable interrupt.
// Latency: cnt/cmp update one cycle after strobe/enable; int_st rises one cycle after cnt==cmp.
// Backpressure: none; strobes are accepted every cycle, writes override increment and disable-clear.
module timer_counter_cmp #(
  parameter logic [63:0] CNT_RST_VAL = 64'h0,
  parameter logic [63:0] CMP_RST_VAL = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cnt_en,
  input  logic        timer_en,
  input  logic        wr_cnt_lo,
  input  logic        wr_cnt_hi,
  input  logic        wr_cmp_lo,
  input  logic        wr_cmp_hi,
  input  logic [31:0] wdata,
  input  logic        int_en,
  input  logic        int_st_clr,
  output logic [63:0] cnt,
  output logic [63:0] cmp,
  output logic        int_st,
  output logic        tim_int
);

  logic        timer_en_d;
  logic        disable_evt;
  logic        cnt_wr;
  logic        cnt_inc;
  logic        match;
  logic [63:0] cnt_next;
  logic [63:0] cmp_next;

  // A 1->0 edge of timer_en clears the counter; cnt_en only counts while the timer is enabled.
  assign disable_evt = timer_en_d & ~timer_en;
  assign cnt_wr      = wr_cnt_lo | wr_cnt_hi;
  assign cnt_inc     = cnt_en & timer_en;

  // Match is taken from registered values so int_st lags the equality by exactly one cycle.
  assign match = (cnt == cmp);

  // Counter next-state: any half write freezes the whole 64 bits except the written half(s).
  always_comb begin
    cnt_next = cnt;
    if (cnt_wr) begin
      if (wr_cnt_lo) cnt_next[31:0]  = wdata;
      if (wr_cnt_hi) cnt_next[63:32] = wdata;
    end else if (disable_evt) begin
      cnt_next = CNT_RST_VAL;
    end else if (cnt_inc) begin
      cnt_next = cnt + 64'd1;
    end
  end

  // Compare next-state: each half loads independently, unaffected by timer_en.
  always_comb begin
    cmp_next = cmp;
    if (wr_cmp_lo) cmp_next[31:0]  = wdata;
    if (wr_cmp_hi) cmp_next[63:32] = wdata;
  end

  // Counter, compare and enable-history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= CNT_RST_VAL;
      cmp        <= CMP_RST_VAL;
      timer_en_d <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      cmp        <= cmp_next;
      timer_en_d <= timer_en;
    end
  end

  // Sticky status: a live match always re-asserts it, so a clear only lands once cnt moves off cmp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_st <= 1'b0;
    end else if (match) begin
      int_st <= 1'b1;
    end else if (int_st_clr) begin
      int_st <= 1'b0;
    end
  end

  // Interrupt line is masked combinationally so int_en takes effect in the same cycle.
  assign tim_int = int_st & int_en;

endmodule

// File: tb/tb_timer_counter_cmp.sv
// Bench for timer_counter_cmp: directed scenarios followed by random traffic.
// Expected values come from a cycle-level behavioural model of the timer rules.
// All inputs change 1 time unit after a rising edge; outputs are checked in the same window.
module tb_timer_counter_cmp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cnt_en, timer_en, wr_cnt_lo, wr_cnt_hi, wr_cmp_lo, wr_cmp_hi;
  logic [31:0] wdata;
  logic        int_en, int_st_clr;
  logic [63:0] cnt, cmp;
  logic        int_st, tim_int;

  always #5 clk = ~clk;

  timer_counter_cmp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt_en     (cnt_en),
    .timer_en   (timer_en),
    .wr_cnt_lo  (wr_cnt_lo),
    .wr_cnt_hi  (wr_cnt_hi),
    .wr_cmp_lo  (wr_cmp_lo),
    .wr_cmp_hi  (wr_cmp_hi),
    .wdata      (wdata),
    .int_en     (int_en),
    .int_st_clr (int_st_clr),
    .cnt        (cnt),
    .cmp        (cmp),
    .int_st     (int_st),
    .tim_int    (tim_int)
  );

  // Reference model state
  logic [63:0] m_cnt, m_cmp;
  logic        m_st, m_en_d;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".cnt"},     cnt,            m_cnt);
    chk({tag, ".cmp"},     cmp,            m_cmp);
    chk({tag, ".int_st"},  64'(int_st),    64'(m_st));
    chk({tag, ".tim_int"}, 64'(tim_int),   64'(m_st & int_en));
  endtask

  task automatic model_reset();
    m_cnt  = 64'h0;
    m_cmp  = 64'hFFFF_FFFF_FFFF_FFFF;
    m_st   = 1'b0;
    m_en_d = 1'b0;
  endtask

  // One clock: predict from the rules, advance, check, then drop one-cycle strobes.
  task automatic step(input string tag);
    logic [63:0] n_cnt, n_cmp;
    logic        n_st;
    logic        hit;
    hit   = (m_cnt == m_cmp);
    n_cnt = m_cnt;
    if (wr_cnt_lo || wr_cnt_hi) begin
      if (wr_cnt_lo) n_cnt = {m_cnt[63:32], wdata};
      if (wr_cnt_hi) n_cnt = {wdata, n_cnt[31:0]};
    end else if (m_en_d && !timer_en) begin
      n_cnt = 64'h0;
    end else if (cnt_en && timer_en) begin
      n_cnt = m_cnt + 64'd1;
    end
    n_cmp = m_cmp;
    if (wr_cmp_lo) n_cmp = {m_cmp[63:32], wdata};
    if (wr_cmp_hi) n_cmp = {wdata, n_cmp[31:0]};
    if (hit)             n_st = 1'b1;
    else if (int_st_clr) n_st = 1'b0;
    else                 n_st = m_st;
    @(posedge clk);
    m_cnt  = n_cnt;
    m_cmp  = n_cmp;
    m_st   = n_st;
    m_en_d = timer_en;
    #1;
    check_all(tag);
    cnt_en = 0; wr_cnt_lo = 0; wr_cnt_hi = 0; wr_cmp_lo = 0; wr_cmp_hi = 0; int_st_clr = 0;
  endtask

  initial begin
    rst_n = 0; cnt_en = 0; timer_en = 0; wr_cnt_lo = 0; wr_cnt_hi = 0;
    wr_cmp_lo = 0; wr_cmp_hi = 0; wdata = 0; int_en = 0; int_st_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1;

    // Basic counting
    timer_en = 1; step("en");
    for (int i = 0; i < 5; i++) begin cnt_en = 1; step("count5"); end
    chk("count5.const", cnt, 64'd5);
    chk("cmp_rst.const", cmp, 64'hFFFF_FFFF_FFFF_FFFF);

    // Carry from low to high half, then wrap
    wr_cnt_hi = 1; wdata = 32'h0; step("ld_hi0");
    wr_cnt_lo = 1; wdata = 32'hFFFF_FFFE; step("ld_lo");
    cnt_en = 1; step("inc_ffff");
    chk("inc_ffff.const", cnt, 64'h0000_0000_FFFF_FFFF);
    cnt_en = 1; step("carry");
    chk("carry.const", cnt, 64'h0000_0001_0000_0000);
    wr_cnt_lo = 1; wr_cnt_hi = 1; wdata = 32'hFFFF_FFFF; step("ld_ones");
    cnt_en = 1; step("wrap");
    chk("wrap.const", cnt, 64'h0);
    step("wrap_st");
    int_st_clr = 1; step("wrap_clr");

    // Compare match, sticky while equal, clear after moving on
    wr_cmp_hi = 1; wdata = 32'h0; step("cmp_hi");
    wr_cmp_lo = 1; wdata = 32'd10; step("cmp_lo");
    wr_cnt_lo = 1; wr_cnt_hi = 1; wdata = 32'h0; step("cnt0");
    int_en = 1;
    for (int i = 0; i < 10; i++) begin cnt_en = 1; step("to10"); end
    chk("at10.cnt", cnt, 64'd10);
    chk("at10.st_not_yet", 64'(int_st), 64'd0);
    step("match");
    chk("match.st", 64'(int_st), 64'd1);
    chk("match.int", 64'(tim_int), 64'd1);
    int_st_clr = 1; step("clr_blocked");
    chk("clr_blocked.const", 64'(int_st), 64'd1);
    cnt_en = 1; step("to11");
    int_st_clr = 1; step("clr_ok");
    chk("clr_ok.const", 64'(int_st), 64'd0);

    // Write beats increment
    wr_cnt_hi = 1; wdata = 32'd5; step("ld5hi");
    wr_cnt_lo = 1; wdata = 32'd7; step("ld7lo");
    wr_cnt_lo = 1; cnt_en = 1; wdata = 32'h1234; step("wr_vs_inc");
    chk("wr_vs_inc.const", cnt, 64'h0000_0005_0000_1234);

    // Disable clear, and write blocking the clear
    wr_cnt_hi = 1; wdata = 32'h0; step("z_hi");
    wr_cnt_lo = 1; wdata = 32'h55; step("ld55");
    timer_en = 0; step("dis_clr");
    chk("dis_clr.const", cnt, 64'h0);
    timer_en = 1; wr_cnt_lo = 1; wdata = 32'h55; step("reen");
    timer_en = 0; wr_cnt_hi = 1; wdata = 32'hA; step("dis_wr");
    chk("dis_wr.const", cnt, 64'h0000_000A_0000_0055);
    cnt_en = 1; step("en0_ignore");

    // Interrupt masking and same-cycle enable
    wr_cmp_hi = 1; wdata = 32'hA; step("cmpA");
    wr_cmp_lo = 1; wdata = 32'h55; step("cmp55");
    step("eq_set");
    int_en = 0; #1;
    chk("mask.tim_int", 64'(tim_int), 64'd0);
    int_en = 1; #1;
    chk("unmask.tim_int", 64'(tim_int), 64'd1);

    // Asynchronous reset mid-count
    timer_en = 1; step("re_en");
    cnt_en = 1; step("run1");
    cnt_en = 1; #1; rst_n = 0; #1;
    model_reset();
    check_all("async_rst");
    #2; cnt_en = 0; rst_n = 1;
    step("post_rst");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) timer_en = ~timer_en;
      if ($urandom_range(0, 7) == 0)  int_en   = ~int_en;
      cnt_en     = ($urandom_range(0, 3) != 0);
      int_st_clr = ($urandom_range(0, 3) == 0);
      wr_cnt_lo  = ($urandom_range(0, 31) == 0);
      wr_cnt_hi  = ($urandom_range(0, 31) == 0);
      wr_cmp_lo  = ($urandom_range(0, 15) == 0);
      wr_cmp_hi  = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       wdata = $urandom;
        1:       wdata = m_cnt[63:32];
        default: wdata = m_cnt[31:0] + 32'($urandom_range(0, 6));
      endcase
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/timer_counter_cmp.md
Name: timer_counter_cmp

Overview:
- 64-bit timer counter stage directly downstream of the divider/halt control block.
- Advances by one on each cycle the upstream count-enable is high; software can load it through 32-bit register halves.
- Compares the count against a 64-bit compare value and raises a sticky, maskable interrupt.
- Feeds the register interface (TDR/TCMR read-back) and the system interrupt line.

Parameters:
- CNT_RST_VAL, 64'h0, counter value after reset and after a timer_en disable clear.
- CMP_RST_VAL, 64'hFFFF_FFFF_FFFF_FFFF, compare value after reset.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cnt_en  input  1  one-cycle increment strobe from upstream control; already gated by halt.
- timer_en  input  1  timer enable bit from the control register.
- wr_cnt_lo  input  1  write strobe, load wdata into cnt[31:0].
- wr_cnt_hi  input  1  write strobe, load wdata into cnt[63:32].
- wr_cmp_lo  input  1  write strobe, load wdata into cmp[31:0].
- wr_cmp_hi  input  1  write strobe, load wdata into cmp[63:32].
- wdata  input  32  write data shared by all write strobes.
- int_en  input  1  interrupt enable bit.
- int_st_clr  input  1  write-1-to-clear strobe for the interrupt status.
- cnt  output  64  current counter value (registered).
- cmp  output  64  current compare value (registered).
- int_st  output  1  sticky interrupt status (registered).
- tim_int  output  1  interrupt line = int_st & int_en (combinational from the int_st register).

Behaviour:
- Reset (async, rst_n=0):
  - cnt=CNT_RST_VAL, cmp=CMP_RST_VAL, int_st=0, timer_en_d=0, tim_int=0.
  - Reset asserted mid-operation discards any in-flight increment or write immediately.
- timer_en_d is a register of timer_en. Disable event = timer_en_d & !timer_en (1->0 edge).
- Counter update priority, per half, highest first:
  - (1) wr_cnt_lo / wr_cnt_hi load that half from wdata.
  - (2) Disable event loads CNT_RST_VAL.
  - (3) cnt_en increments.
  - (4) Otherwise hold.
- Any cnt write in a cycle blocks both the increment and the clear for the whole 64 bits that cycle. The unwritten half holds its value.
- wr_cnt_lo and wr_cnt_hi together load all 64 bits in one cycle.
- Increment is a full 64-bit add with carry from the low half into the high half.
- Wrap: FFFF_FFFF_FFFF_FFFF + 1 -> 0, with no extra flag.
- cnt_en while timer_en=0 is ignored; upstream does not generate it, and the counter still must not move.
- Compare register: each half loads from wdata on its strobe, otherwise holds. It is not affected by timer_en.
- Match: match = (cnt == cmp), using registered values; latency 1 cycle from cnt reaching cmp to int_st=1.
- int_st:
  - Set on any cycle match=1, regardless of int_en or timer_en.
  - Cleared on int_st_clr=1 only when match=0. Set wins over a simultaneous clear.
  - While cnt stays equal to cmp (counter stopped/halted), int_st cannot be cleared.
- Writing cmp equal to the current cnt sets int_st on the following cycle.
- tim_int follows int_en combinationally. Enabling int_en with int_st=1 asserts tim_int in the same cycle.
- Read-back: cnt and cmp reflect writes one cycle after the strobe.

Test Plan:
- Reset, then timer_en=1, cnt_en high 5 cycles -> cnt=5, cmp=FFFF_FFFF_FFFF_FFFF, int_st=0, tim_int=0.
- Load cnt=0000_0000_FFFF_FFFE, one cnt_en pulse -> FFFF_FFFF; next pulse -> 0000_0001_0000_0000 (carry). Load all-ones, one pulse -> 0 (wrap).
- Load cmp=10, int_en=1, count from 0 -> int_st and tim_int rise the cycle after cnt==10. int_st_clr while cnt=10 held -> int_st stays 1. One more cnt_en then int_st_clr -> int_st=0.
- wr_cnt_lo with wdata=0x1234 in the same cycle as cnt_en, from cnt=0000_0005_0000_0007 -> cnt=0000_0005_0000_1234 (write wins, no increment).
- timer_en 1->0 with cnt=0x55 -> cnt=0 next cycle. Same cycle also wr_cnt_hi=0xA -> cnt=0000_000A_0000_0055 (write blocks the clear).
- int_st=1, int_en=0 -> tim_int=0. Raise int_en -> tim_int=1 same cycle. Pulse rst_n low mid-count -> all outputs return to reset values immediately.
